feature_stream_fifo: RTL and testbench

FEATURE_STREAM_FIFO -- requirements
Module: feature_stream_fifo

---
 rtl/feature_stream_fifo.sv | 96 +++++++++
 tb/tb_feature_stream_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/feature_stream_fifo.sv
// First-word-fall-through FIFO feeding the convolution pipeline from the host
// write stream, with frame tracking (tlast / frame_done) and a sticky overflow flag.
module feature_stream_fifo #(
    parameter int DEPTH       = 16,
    parameter int FRAME_WORDS = 1024
) (
    input  logic                       bus_clk,
    input  logic                       bus_rst,
    input  logic                       user_w_write_feature_32_wren,
    input  logic [31:0]                user_w_write_feature_32_data,
    input  logic                       user_w_write_feature_32_open,
    output logic                       user_w_write_feature_32_full,
    output logic [31:0]                feat_tdata,
    output logic                       feat_tvalid,
    input  logic                       feat_tready,
    output logic                       feat_tlast,
    output logic                       frame_done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [15:0]    LAST_CNT = 16'(FRAME_WORDS - 1);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [15:0]   r_frame_cnt;
    logic          r_open_prev;
    logic          r_overflow;
    logic          r_frame_done;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_last;
    logic w_open_edge;

    assign w_full      = (r_level == FULL_LVL);
    assign w_valid     = (r_level != '0);
    assign w_push      = user_w_write_feature_32_wren && !w_full && !bus_rst;
    assign w_pop       = w_valid && feat_tready;
    assign w_last      = w_valid && (r_frame_cnt == LAST_CNT);
    assign w_open_edge = user_w_write_feature_32_open && !r_open_prev;

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge bus_clk) begin
        if (w_push) r_mem[r_wptr] <= user_w_write_feature_32_data;
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Open-edge clear wins over a coincident pop or overflow event.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_frame_cnt  <= '0;
            r_open_prev  <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_open_prev  <= user_w_write_feature_32_open;
            r_frame_done <= w_pop && w_last;
            if (w_open_edge) begin
                r_frame_cnt <= '0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_pop) r_frame_cnt <= (r_frame_cnt == LAST_CNT) ? 16'd0 : r_frame_cnt + 16'd1;
                if (user_w_write_feature_32_wren && w_full) r_overflow <= 1'b1;
            end
        end
    end

    assign user_w_write_feature_32_full = w_full;
    assign feat_tdata  = r_mem[r_rptr];
    assign feat_tvalid = w_valid;
    assign feat_tlast  = w_last;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign level       = r_level;
endmodule

// File: tb/tb_feature_stream_fifo.sv
// Directed bench for feature_stream_fifo: fill/drain, overflow, framing,
// concurrency, mid-frame reset and a randomized-ready wrap run.
module tb_feature_stream_fifo;
    localparam int DEPTH = 16;
    localparam int FW    = 4;
    localparam int NWRAP = 3*DEPTH + 5;

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b1;
    logic        wren    = 1'b0;
    logic [31:0] wdata   = '0;
    logic        wopen   = 1'b0;
    logic        full;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready  = 1'b0;
    logic        tlast;
    logic        fdone;
    logic        ovf;
    logic [4:0]  lvl;

    int errs   = 0;
    int checks = 0;

    always #5 bus_clk = ~bus_clk;

    feature_stream_fifo #(.DEPTH(DEPTH), .FRAME_WORDS(FW)) dut (
        .bus_clk                      (bus_clk),
        .bus_rst                      (bus_rst),
        .user_w_write_feature_32_wren (wren),
        .user_w_write_feature_32_data (wdata),
        .user_w_write_feature_32_open (wopen),
        .user_w_write_feature_32_full (full),
        .feat_tdata                   (tdata),
        .feat_tvalid                  (tvalid),
        .feat_tready                  (tready),
        .feat_tlast                   (tlast),
        .frame_done                   (fdone),
        .overflow                     (ovf),
        .level                        (lvl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    initial begin
        int sent, recv, cyc;
        step(); step();
        chk("rst_level", 32'(lvl), 0);
        chk("rst_valid", 32'(tvalid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_fdone", 32'(fdone), 0);

        bus_rst = 1'b0; wopen = 1'b1;
        step();

        // fill with ready low
        for (int i = 1; i <= DEPTH; i++) begin
            wren = 1'b1; wdata = 32'(i);
            step();
            chk("fill_level", 32'(lvl), 32'(i));
        end
        wren = 1'b0;
        chk("fill_full", 32'(full), 1);
        chk("fill_head", tdata, 1);

        // overflow while full
        wren = 1'b1; wdata = 32'hDEADBEEF;
        step();
        wren = 1'b0;
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_level", 32'(lvl), 16);
        step();
        chk("ovf_sticky", 32'(ovf), 1);

        // drain in order; tlast every FW words
        tready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_data", tdata, 32'(i));
            chk("drain_tlast", 32'(tlast), 32'(i % FW == 0));
            step();
            chk("drain_fdone", 32'(fdone), 32'(i % FW == 0));
            if (i == 1) chk("drain_full_off", 32'(full), 0);
        end
        chk("drain_empty", 32'(tvalid), 0);
        chk("drain_level", 32'(lvl), 0);

        // open rising edge clears overflow
        wopen = 1'b0; step();
        wopen = 1'b1; step();
        chk("open_clr_ovf", 32'(ovf), 0);

        // streaming frames: push+pop each cycle keeps level at 1
        for (int k = 0; k < 8; k++) begin
            wren = 1'b1; wdata = 32'(100 + k);
            step();
            chk("frm_data", tdata, 32'(100 + k));
            chk("frm_tlast", 32'(tlast), 32'(k % FW == FW - 1));
            chk("frm_level", 32'(lvl), 1);
            chk("frm_fdone", 32'(fdone), 32'(k > 0 && ((k - 1) % FW == FW - 1)));
        end
        wren = 1'b0;
        step();
        chk("frm_fdone_last", 32'(fdone), 1);
        chk("frm_level_end", 32'(lvl), 0);
        step();
        chk("frm_fdone_pulse", 32'(fdone), 0);

        // mid-frame reset at level 7
        tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wren = 1'b1; wdata = 32'(200 + i);
            step();
        end
        wren = 1'b0; tready = 1'b1;
        step(); step();
        tready = 1'b0;
        chk("prerst_level", 32'(lvl), 7);
        chk("prerst_head", tdata, 202);
        bus_rst = 1'b1; wren = 1'b1; wdata = 32'hBAD0BAD0; tready = 1'b1;
        step();
        chk("midrst_level", 32'(lvl), 0);
        chk("midrst_valid", 32'(tvalid), 0);
        chk("midrst_tlast", 32'(tlast), 0);
        bus_rst = 1'b0; wren = 1'b0; tready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            wren = 1'b1; wdata = 32'(300 + i);
            step();
        end
        wren = 1'b0;
        chk("postrst_level", 32'(lvl), 4);
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("postrst_data", tdata, 32'(300 + i));
            chk("postrst_tlast", 32'(tlast), 32'(i == 3));
            step();
        end
        tready = 1'b0;

        // wrap run with random ready
        sent = 0; recv = 0; cyc = 0;
        while (recv < NWRAP && cyc < 2000) begin
            wren   = (sent < NWRAP) && !full && ($urandom_range(3) != 0);
            wdata  = 32'hA000_0000 + 32'(sent);
            tready = $urandom_range(1) == 1;
            if (tvalid && tready) begin
                chk("wrap_data", tdata, 32'hA000_0000 + 32'(recv));
                recv++;
            end
            if (wren) sent++;
            step();
            cyc++;
        end
        wren = 1'b0; tready = 1'b0;
        chk("wrap_count", 32'(recv), 32'(NWRAP));
        chk("wrap_ovf", 32'(ovf), 0);
        chk("wrap_level", 32'(lvl), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
